// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the memory stage and data_mem_ctrl.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the request fields are sampled on that edge only.
// The requester may raise or drop req_valid at any time. Exactly one
// single-cycle resp_valid strobe follows each transfer. read_data, err_align
// and err_range are meaningful only while resp_valid is high.
interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        err_align;
    logic        err_range;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, address, write_data,
        input  req_ready, resp_valid, read_data, err_align, err_range
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, address, write_data,
        output req_ready, resp_valid, read_data, err_align, err_range
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Wait-stated byte/half/word data memory with lane merging, load extension
// and alignment/range error flags. One access per WAIT_STATES+2 cycles.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    data_mem_ctrl_if.slave     bus,
    output logic [1:0]         dbg_state
);

    localparam int          DEPTH    = 1 << (ADDR_WIDTH - 2);
    localparam logic [3:0]  LAST_CNT = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic        align_q, align_d;
    logic        range_q, range_d;

    // Storage starts at zero and is deliberately left untouched by reset.
    logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

    logic                  accept;
    logic                  access_en;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [1:0]            acc_size;
    logic                  acc_write;
    logic                  acc_uns;
    logic                  err_align_c;
    logic                  err_range_c;
    logic [ADDR_WIDTH-3:0] mem_idx;
    logic [31:0]           mem_word;
    logic [31:0]           lane_word;
    logic [31:0]           load_val;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;

    assign bus.req_ready  = (state_q == S_IDLE) && rst_n;
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.read_data  = rdata_q;
    assign bus.err_align  = align_q;
    assign bus.err_range  = range_q;
    assign dbg_state      = state_q;

    assign accept = bus.req_valid && bus.req_ready;

    // Next-state, wait counter and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        write_d = write_q;
        uns_d   = uns_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = bus.address;
                    wdata_d = bus.write_data;
                    size_d  = bus.req_size;
                    write_d = bus.req_write;
                    uns_d   = bus.req_unsigned;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Access decode: with no wait states the access happens on the accept
    // edge itself, so the live request fields are used instead of the captures.
    always_comb begin
        acc_addr  = (WAIT_STATES == 0) ? bus.address      : addr_q;
        acc_wdata = (WAIT_STATES == 0) ? bus.write_data   : wdata_q;
        acc_size  = (WAIT_STATES == 0) ? bus.req_size     : size_q;
        acc_write = (WAIT_STATES == 0) ? bus.req_write    : write_q;
        acc_uns   = (WAIT_STATES == 0) ? bus.req_unsigned : uns_q;
        access_en = (WAIT_STATES == 0) ? accept
                                       : ((state_q == S_WAIT) && (cnt_q == LAST_CNT));

        err_align_c = ((acc_size == 2'b01) && acc_addr[0])
                   || ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00))
                   ||  (acc_size == 2'b11);
        err_range_c = ((acc_addr >> ADDR_WIDTH) != 32'd0);

        mem_idx   = acc_addr[ADDR_WIDTH-1:2];
        mem_word  = mem_q[mem_idx];
        lane_word = mem_word >> {acc_addr[1:0], 3'b000};

        load_val  = mem_word;
        mem_be    = 4'b1111;
        mem_wdata = acc_wdata;
        unique case (acc_size)
            2'b00: begin
                load_val  = acc_uns ? {24'h0, lane_word[7:0]}
                                    : {{24{lane_word[7]}}, lane_word[7:0]};
                mem_be    = 4'b0001 << acc_addr[1:0];
                mem_wdata = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                load_val  = acc_uns ? {16'h0, lane_word[15:0]}
                                    : {{16{lane_word[15]}}, lane_word[15:0]};
                mem_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{acc_wdata[15:0]}};
            end
            default: begin
                load_val  = mem_word;
                mem_be    = 4'b1111;
                mem_wdata = acc_wdata;
            end
        endcase

        mem_we = access_en && acc_write && !err_align_c && !err_range_c;

        rdata_d = rdata_q;
        align_d = align_q;
        range_d = range_q;
        if (access_en) begin
            align_d = err_align_c;
            range_d = err_range_c;
            rdata_d = (acc_write || err_align_c || err_range_c) ? 32'h0 : load_val;
        end
    end

    // Control and response registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'b00;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            rdata_q <= 32'h0;
            align_q <= 1'b0;
            range_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            write_q <= write_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            align_q <= align_d;
            range_q <= range_d;
        end
    end

    // Byte-lane write merge into the addressed word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (0, 1 and 3 wait states) share one
// stimulus bus; sel picks which instance sees req_valid and is monitored.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int          sel = 1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;

  data_mem_ctrl_if if_ws0();
  data_mem_ctrl_if if_ws1();
  data_mem_ctrl_if if_ws3();

  assign if_ws0.req_valid    = req_valid && (sel == 0);
  assign if_ws1.req_valid    = req_valid && (sel == 1);
  assign if_ws3.req_valid    = req_valid && (sel == 3);
  assign if_ws0.req_write    = req_write;
  assign if_ws1.req_write    = req_write;
  assign if_ws3.req_write    = req_write;
  assign if_ws0.req_size     = req_size;
  assign if_ws1.req_size     = req_size;
  assign if_ws3.req_size     = req_size;
  assign if_ws0.req_unsigned = req_unsigned;
  assign if_ws1.req_unsigned = req_unsigned;
  assign if_ws3.req_unsigned = req_unsigned;
  assign if_ws0.address      = address;
  assign if_ws1.address      = address;
  assign if_ws3.address      = address;
  assign if_ws0.write_data   = write_data;
  assign if_ws1.write_data   = write_data;
  assign if_ws3.write_data   = write_data;

  logic [1:0] dbg_ws0, dbg_ws1, dbg_ws3;

  data_mem_ctrl #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .bus(if_ws0), .dbg_state(dbg_ws0));
  data_mem_ctrl #(.ADDR_WIDTH(12), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n), .bus(if_ws1), .dbg_state(dbg_ws1));
  data_mem_ctrl #(.ADDR_WIDTH(12), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .bus(if_ws3), .dbg_state(dbg_ws3));

  // outputs of the selected instance, plus any response from the others
  logic        cur_ready, cur_resp;
  logic [31:0] cur_data;
  logic        cur_align, cur_range;
  logic        other_resp;

  always_comb begin
    cur_ready  = if_ws1.req_ready;
    cur_resp   = if_ws1.resp_valid;
    cur_data   = if_ws1.read_data;
    cur_align  = if_ws1.err_align;
    cur_range  = if_ws1.err_range;
    other_resp = if_ws0.resp_valid || if_ws3.resp_valid;
    if (sel == 0) begin
      cur_ready  = if_ws0.req_ready;
      cur_resp   = if_ws0.resp_valid;
      cur_data   = if_ws0.read_data;
      cur_align  = if_ws0.err_align;
      cur_range  = if_ws0.err_range;
      other_resp = if_ws1.resp_valid || if_ws3.resp_valid;
    end else if (sel == 3) begin
      cur_ready  = if_ws3.req_ready;
      cur_resp   = if_ws3.resp_valid;
      cur_data   = if_ws3.read_data;
      cur_align  = if_ws3.err_align;
      cur_range  = if_ws3.err_range;
      other_resp = if_ws0.resp_valid || if_ws1.resp_valid;
    end
  end

  // scoreboard: expected {err_range, err_align, read_data} and response cycle
  logic [33:0] exp_q[$];
  int          cyc_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ready_due = -1;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [33:0] rsp(input logic rg, input logic al, input logic [31:0] d);
    return {rg, al, d};
  endfunction

  // monitor: pops the scoreboard whenever the selected instance responds
  always @(negedge clk) begin
    logic [33:0] e;
    int          ec;
    string       nm;
    check("stray_resp_other_instance", {33'h0, other_resp}, 34'h0);
    if (rst_n && ready_due == cyc) check("ready_after_resp", {33'h0, cur_ready}, 34'h1);
    if (rst_n && exp_q.size() != 0) check("ready_low_while_busy", {33'h0, cur_ready}, 34'h0);
    if (cur_resp) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 34'h1, 34'h0);
      end else begin
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        nm = name_q.pop_front();
        check(nm, {cur_range, cur_align, cur_data}, e);
        check({nm, "_latency"}, 34'(cyc), 34'(ec));
        ready_due = cyc + 1;
      end
    end
  end

  // driver: issue one request, then wait (bounded) for its response
  task automatic issue(input string name, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [33:0] exp, input bit toggle);
    int guard = 0;
    int acc;
    @(negedge clk);
    while (!cur_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cur_ready) begin
      check({name, "_ready_timeout"}, 34'h0, 34'h1);
      return;
    end
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    address      = addr;
    write_data   = wd;
    req_valid    = 1'b1;
    acc          = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_q.push_back(exp);
    cyc_q.push_back(acc + 1 + sel);
    name_q.push_back(name);
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      if (toggle) req_valid = 1'($urandom_range(0, 1));
      guard++;
    end
    req_valid = 1'b0;
    if (exp_q.size() != 0) begin
      check({name, "_resp_timeout"}, 34'h0, 34'h1);
      exp_q.delete();
      cyc_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    // reset state and idle behaviour
    sel = 1;
    repeat (2) @(negedge clk);
    check("reset_ready", {33'h0, cur_ready}, 34'h0);
    check("reset_resp_valid", {33'h0, cur_resp}, 34'h0);
    check("reset_outputs", {cur_range, cur_align, cur_data}, 34'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {33'h0, cur_ready}, 34'h1);
    repeat (20) begin
      @(negedge clk);
      check("idle_no_resp", {33'h0, cur_resp}, 34'h0);
    end

    // word, byte and half accesses, 1 wait state
    issue("sw_10",       1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rsp(0, 0, 32'h0), 0);
    issue("lw_10",       0, 2'b10, 0, 32'h10, 32'h0,        rsp(0, 0, 32'hDEADBEEF), 0);
    issue("sb_13",       1, 2'b00, 0, 32'h13, 32'hAAAAAA55, rsp(0, 0, 32'h0), 0);
    issue("lw_10_sb",    0, 2'b10, 0, 32'h10, 32'h0,        rsp(0, 0, 32'h55ADBEEF), 0);
    issue("lb_13",       0, 2'b00, 0, 32'h13, 32'h0,        rsp(0, 0, 32'h00000055), 0);
    issue("lb_12",       0, 2'b00, 0, 32'h12, 32'h0,        rsp(0, 0, 32'hFFFFFFAD), 0);
    issue("lbu_12",      0, 2'b00, 1, 32'h12, 32'h0,        rsp(0, 0, 32'h000000AD), 0);
    issue("sh_10",       1, 2'b01, 0, 32'h10, 32'hFFFF1234, rsp(0, 0, 32'h0), 0);
    issue("lw_10_sh",    0, 2'b10, 0, 32'h10, 32'h0,        rsp(0, 0, 32'h55AD1234), 0);
    issue("lh_12",       0, 2'b01, 0, 32'h12, 32'h0,        rsp(0, 0, 32'h000055AD), 0);
    issue("sw_40",       1, 2'b10, 0, 32'h40, 32'h80017FFF, rsp(0, 0, 32'h0), 0);
    issue("lh_42",       0, 2'b01, 0, 32'h42, 32'h0,        rsp(0, 0, 32'hFFFF8001), 0);
    issue("lhu_42",      0, 2'b01, 1, 32'h42, 32'h0,        rsp(0, 0, 32'h00008001), 0);
    issue("lb_40",       0, 2'b00, 0, 32'h40, 32'h0,        rsp(0, 0, 32'hFFFFFFFF), 0);
    issue("lbu_41",      0, 2'b00, 1, 32'h41, 32'h0,        rsp(0, 0, 32'h0000007F), 0);
    issue("lw_40_uns",   0, 2'b10, 1, 32'h40, 32'h0,        rsp(0, 0, 32'h80017FFF), 0);
    issue("sw_ffc",      1, 2'b10, 0, 32'hFFC, 32'hA5A50001, rsp(0, 0, 32'h0), 0);
    issue("lw_ffc",      0, 2'b10, 0, 32'hFFC, 32'h0,       rsp(0, 0, 32'hA5A50001), 0);

    // error responses
    issue("lw_0e_align", 0, 2'b10, 0, 32'h0E, 32'h0,        rsp(0, 1, 32'h0), 0);
    issue("sh_11_align", 1, 2'b01, 0, 32'h11, 32'h0000BBBB, rsp(0, 1, 32'h0), 0);
    issue("lw_10_after_sh_err", 0, 2'b10, 0, 32'h10, 32'h0, rsp(0, 0, 32'h55AD1234), 0);
    issue("lw_1000_range", 0, 2'b10, 0, 32'h1000, 32'h0,    rsp(1, 0, 32'h0), 0);
    issue("sw_1010_range", 1, 2'b10, 0, 32'h1010, 32'hFFFFFFFF, rsp(1, 0, 32'h0), 0);
    issue("lw_10_after_range", 0, 2'b10, 0, 32'h10, 32'h0,  rsp(0, 0, 32'h55AD1234), 0);
    issue("ld_size11",   0, 2'b11, 0, 32'h10, 32'h0,        rsp(0, 1, 32'h0), 0);
    issue("st_size11",   1, 2'b11, 0, 32'h10, 32'h0,        rsp(0, 1, 32'h0), 0);
    issue("lw_10_after_sz11", 0, 2'b10, 0, 32'h10, 32'h0,   rsp(0, 0, 32'h55AD1234), 0);
    issue("lw_1002_both", 0, 2'b10, 0, 32'h1002, 32'h0,     rsp(1, 1, 32'h0), 0);

    // zero wait states, req_valid toggled while busy
    sel = 0;
    issue("ws0_sw_08",   1, 2'b10, 0, 32'h08, 32'h11223344, rsp(0, 0, 32'h0), 1);
    issue("ws0_lw_08",   0, 2'b10, 0, 32'h08, 32'h0,        rsp(0, 0, 32'h11223344), 1);
    issue("ws0_lb_0b",   0, 2'b00, 0, 32'h0B, 32'h0,        rsp(0, 0, 32'h00000011), 1);
    issue("ws0_lh_0a",   0, 2'b01, 0, 32'h0A, 32'h0,        rsp(0, 0, 32'h00001122), 0);
    issue("ws0_sb_09",   1, 2'b00, 0, 32'h09, 32'h000000F0, rsp(0, 0, 32'h0), 1);
    issue("ws0_lw_08_sb", 0, 2'b10, 0, 32'h08, 32'h0,       rsp(0, 0, 32'h1122F044), 1);
    issue("ws0_lw_1000", 0, 2'b10, 0, 32'h1000, 32'h0,      rsp(1, 0, 32'h0), 0);

    // three wait states, req_valid toggled while busy
    sel = 3;
    issue("ws3_sw_30",   1, 2'b10, 0, 32'h30, 32'hAABBCCDD, rsp(0, 0, 32'h0), 1);
    issue("ws3_lw_30",   0, 2'b10, 0, 32'h30, 32'h0,        rsp(0, 0, 32'hAABBCCDD), 1);
    issue("ws3_lhu_32",  0, 2'b01, 1, 32'h32, 32'h0,        rsp(0, 0, 32'h0000AABB), 1);
    issue("ws3_lh_32",   0, 2'b01, 0, 32'h32, 32'h0,        rsp(0, 0, 32'hFFFFAABB), 1);
    issue("ws3_lw_0e",   0, 2'b10, 0, 32'h0E, 32'h0,        rsp(0, 1, 32'h0), 0);

    // reset in the middle of a 3-wait-state store: no response, no commit
    guard = 0;
    @(negedge clk);
    while (!cur_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("abort_ready_before", {33'h0, cur_ready}, 34'h1);
    req_write  = 1'b1;
    req_size   = 2'b10;
    address    = 32'h20;
    write_data = 32'hCAFEF00D;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ready_in_reset", {33'h0, cur_ready}, 34'h0);
    check("abort_resp_in_reset", {33'h0, cur_resp}, 34'h0);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("abort_no_resp", {33'h0, cur_resp}, 34'h0);
    end
    issue("ws3_lw_20_after_abort", 0, 2'b10, 0, 32'h20, 32'h0, rsp(0, 0, 32'h0), 0);
    issue("ws3_lw_30_after_reset", 0, 2'b10, 0, 32'h30, 32'h0, rsp(0, 0, 32'hAABBCCDD), 0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 34'(exp_q.size()), 34'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, wait-stated data memory for the MIPS multi-cycle processor. It extends the flat word-only data memory with byte, halfword and word accesses, byte-lane write merging, and sign/zero extension of sub-word loads. It also adds a valid/ready request handshake with configurable access latency, and alignment and range error reporting. It sits between the datapath's memory stage (address from ALUOut, store data from register B) and the control FSM, which waits on `resp_valid`.

## Interface
- `ADDR_WIDTH`, 12: byte-address bits decoded; capacity is 2**ADDR_WIDTH bytes, i.e. 2**(ADDR_WIDTH-2) words.
- `WAIT_STATES`, 1: extra cycles inserted before each access (0..15).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `address`  in  32  byte address.
- `write_data`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  one-cycle response strobe.
- `read_data`  out  32  extended load result.
- `err_align`  out  1  response flag: misaligned or reserved size.
- `err_range`  out  1  response flag: address[31:ADDR_WIDTH] nonzero.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - WAIT: counts WAIT_STATES cycles.
  - RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- Transitions:
  - Accept when `req_valid && req_ready`.
  - On accept, go to WAIT (WAIT_STATES>0) or directly to RESP (WAIT_STATES=0).
  - On accept, address, write_data, size, write and unsigned are captured.
  - Request inputs are ignored outside IDLE.
- Access edge: the memory access and the error evaluation occur on the edge that enters RESP. With WAIT_STATES=0 this is the accept edge, and the live inputs are used. Otherwise the captured values are used.
- Errors:
  - `err_align` = (half && addr[0]) || (word && addr[1:0]≠0) || size==11.
  - `err_range` = address above capacity.
  - Either error suppresses the write, forces `read_data`=0, and still produces a normal response.
- Stores:
  - Word index is address[ADDR_WIDTH-1:2].
  - sb writes lane address[1:0] with write_data[7:0].
  - sh writes lanes {address[1],0} and {address[1],1} with write_data[15:0].
  - sw writes all lanes.
  - Unwritten lanes keep their contents.
  - Store responses return `read_data`=0.
- Loads: select the lane(s) by address[1:0] (little-endian lane 0 = bits [7:0]), then extend to 32 bits per `req_unsigned`. `req_unsigned` is ignored for word loads.
- `read_data`, `err_align` and `err_range` are registered at the access edge and held until the next access edge. They are meaningful only while `resp_valid`=1.
- Storage array initialised to zero at time 0. It is not cleared by reset.

## Timing
- Reset (rst_n=0, asynchronous):
  - State IDLE, counter 0.
  - `req_ready`=0 while rst_n low, and 1 from the first cycle after deassertion.
  - `resp_valid`=0, `read_data`=0, `err_align`=0, `err_range`=0.
- Latency: request accepted in cycle 0 → `resp_valid` high in cycle 1+WAIT_STATES → `req_ready` high in cycle 2+WAIT_STATES.
- Back-to-back throughput is one access per WAIT_STATES+2 cycles. `req_ready` is low throughout WAIT and RESP.
- Reset mid-operation aborts the transaction with no response. A store not yet at its access edge is not committed.
- Load after store to the same word observes the stored data, because the store commits before the next accept.
- `resp_valid` never asserts without a preceding accept, and asserts exactly once per accept.

## Test plan
- Reset then idle, WAIT_STATES=1: after rst_n rises, `req_ready`=1 and `resp_valid` stays 0 for 20 cycles with `req_valid`=0.
- Word store/load, WAIT_STATES=1:
  - sw 0xDEADBEEF @0x10, accepted cycle 0 → `resp_valid` cycle 2, `req_ready` cycle 3.
  - lw @0x10 → `read_data`=0xDEADBEEF, no errors.
- Byte/half merge:
  - After the word store above, sb 0x55 @0x13 then lw @0x10 → 0x55ADBEEF.
  - lb @0x13 → 0x00000055. lb @0x12 → 0xFFFFFFAD. lbu @0x12 → 0x000000AD.
  - sh 0x1234 @0x10 then lw → 0x55AD1234.
  - lh @0x12 → 0x000055AD.
- Errors:
  - lw @0x0E → `err_align`=1, `read_data`=0.
  - sh @0x11 → `err_align`=1; a subsequent lw shows the word unchanged.
  - lw @0x1000 with ADDR_WIDTH=12 → `err_range`=1.
  - size=11 → `err_align`=1.
- Latency sweep: WAIT_STATES=0 and 3.
  - `resp_valid` in cycles 1 and 4 respectively.
  - `req_valid` toggled during WAIT/RESP is ignored, with no extra responses.
- Reset mid-op, WAIT_STATES=3:
  - sw 0xCAFEF00D @0x20 accepted, rst_n pulsed low in cycle 2 → no `resp_valid`.
  - A following lw @0x20 returns the previous contents (0 from init).
